// File: rtl/mouse_event_queue.sv
// mouse_event_queue: polls a PS/2 mouse register block and queues cursor/button change events.
// Optional macro MOUSE_BTN_EDGE_EN widens each event word with a 3-bit button-press field.
module mouse_event_queue #(
   parameter int POLL_DIV = 1000,
   parameter int DEPTH    = 8,
   localparam int AW      = $clog2(DEPTH),
`ifdef MOUSE_BTN_EDGE_EN
   localparam int EW      = 24
`else
   localparam int EW      = 21
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [8:0]    m_data,
   output logic [1:0]    m_addr,
   output logic          m_cs,
   input  logic          poll_en,
   input  logic          pop,
   output logic [EW-1:0] evt,
   output logic          evt_valid,
   output logic          irq,
   output logic          overflow,
   output logic [AW:0]   count
);

   localparam int DW = $clog2(POLL_DIV);

   typedef enum logic [2:0] {IDLE, RD_STAT, RD_X, RD_Y, CMP} state_t;

   state_t        state;
   logic [DW-1:0] div;
   logic          tick;

   logic [2:0]    cap_btn;
   logic [8:0]    cap_x;
   logic [8:0]    cap_y;
   logic [2:0]    sh_btn;
   logic [8:0]    sh_x;
   logic [8:0]    sh_y;

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] evt_new;

   logic          changed;
   logic          full;
   logic          do_pop;
   logic          push_ok;

   assign tick = (div == DW'(POLL_DIV - 1));

`ifdef MOUSE_BTN_EDGE_EN
   logic [2:0] press;
   assign press   = cap_btn & ~sh_btn;
   assign evt_new = {press, cap_btn, cap_x, cap_y};
`else
   assign evt_new = {cap_btn, cap_x, cap_y};
`endif

   // Event generation and FIFO occupancy logic
   assign changed   = (state == CMP) &&
                      ({cap_btn, cap_x, cap_y} != {sh_btn, sh_x, sh_y});
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign evt_valid = (wr_ptr != rd_ptr);
   assign do_pop    = pop && evt_valid;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push_ok   = changed && (!full || do_pop);
   assign count     = wr_ptr - rd_ptr;
   assign evt       = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div      <= '0;
         state    <= IDLE;
         m_addr   <= 2'd0;
         m_cs     <= 1'b0;
         sh_btn   <= 3'd0;
         sh_x     <= 9'd204;
         sh_y     <= 9'd153;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         irq      <= 1'b0;
      end else begin
         div <= tick ? '0 : div + DW'(1);
         irq <= evt_valid;
         if (do_pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
         if (push_ok)
            wr_ptr <= wr_ptr + (AW+1)'(1);

         case (state)
            IDLE: begin
               if (tick && poll_en) begin
                  state  <= RD_STAT;
                  m_cs   <= 1'b1;
                  m_addr <= 2'd0;
               end
            end
            RD_STAT: begin
               state  <= RD_X;
               m_addr <= 2'd1;
            end
            RD_X: begin
               state  <= RD_Y;
               m_addr <= 2'd2;
            end
            RD_Y: begin
               state  <= CMP;
               m_cs   <= 1'b0;
               m_addr <= 2'd0;
            end
            CMP: begin
               state  <= IDLE;
               // Shadow tracks the latest sample even when the event is dropped.
               sh_btn <= cap_btn;
               sh_x   <= cap_x;
               sh_y   <= cap_y;
               if (changed && !push_ok)
                  overflow <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Each read state samples m_data at the end of its single cycle
   always_ff @(posedge clk) begin
      case (state)
         RD_STAT: cap_btn <= m_data[2:0];
         RD_X:    cap_x   <= m_data;
         RD_Y:    cap_y   <= m_data;
         default: ;
      endcase
      if (push_ok)
         mem[wr_ptr[AW-1:0]] <= evt_new;
   end

endmodule

// File: tb/tb_mouse_event_queue.sv
// Testbench for mouse_event_queue: event-level reference model with randomized mouse motion and pops.
module tb_mouse_event_queue;
   localparam int PD = 4;
   localparam int DP = 4;
`ifdef MOUSE_BTN_EDGE_EN
   localparam int EW = 24;
`else
   localparam int EW = 21;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [8:0]    m_data;
   logic [1:0]    m_addr;
   logic          m_cs;
   logic          poll_en = 1'b0;
   logic          pop = 1'b0;
   logic [EW-1:0] evt;
   logic          evt_valid;
   logic          irq;
   logic          overflow;
   logic [2:0]    count;

   logic [2:0]    mb = 3'd0;
   logic [8:0]    mx = 9'd204;
   logic [8:0]    my = 9'd153;

   always #5 clk = ~clk;

   // Mouse register block: combinational read data
   assign m_data = (m_addr == 2'd0) ? {6'd0, mb} :
                   (m_addr == 2'd1) ? mx :
                   (m_addr == 2'd2) ? my : 9'd0;

   mouse_event_queue #(.POLL_DIV(PD), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst), .m_data(m_data), .m_addr(m_addr), .m_cs(m_cs),
      .poll_en(poll_en), .pop(pop), .evt(evt), .evt_valid(evt_valid),
      .irq(irq), .overflow(overflow), .count(count)
   );

   int total = 0;
   int bad = 0;

   // Reference model state
   logic [EW-1:0] q[$];
   bit            ovf_m;
   bit            irq_m;
   logic [2:0]    shb, capb;
   logic [8:0]    shx, shy, capx, capy;
   int            n;
   int            s;
   int            sweeps;

   function automatic logic [EW-1:0] mk_evt(logic [2:0] b, logic [8:0] x, logic [8:0] y,
                                            logic [2:0] prevb);
      logic [EW-1:0] e;
`ifdef MOUSE_BTN_EDGE_EN
      e = {b & ~prevb, b, x, y};
`else
      e = {b, x, y} | EW'(prevb & 3'd0);
`endif
      return e;
   endfunction

   task automatic model_reset();
      q.delete();
      ovf_m  = 1'b0;
      irq_m  = 1'b0;
      shb    = 3'd0;
      shx    = 9'd204;
      shy    = 9'd153;
      n      = 0;
      s      = -100;
      sweeps = 0;
   endtask

   // Advance the model across the edge ending cycle n, using the inputs now driven.
   task automatic model_eval();
      bit            popeff, do_push, acc, irq_next;
      logic [EW-1:0] ev;
      irq_next = (q.size() != 0);
      popeff   = pop && (q.size() != 0);
      do_push  = 1'b0;
      ev       = '0;
      if (n == s + 1) capb = mb;
      if (n == s + 2) capx = mx;
      if (n == s + 3) capy = my;
      if (n == s + 4) begin
         sweeps++;
         if ({capb, capx, capy} != {shb, shx, shy}) begin
            do_push = 1'b1;
            ev = mk_evt(capb, capx, capy, shb);
         end
         shb = capb;
         shx = capx;
         shy = capy;
      end
      acc = do_push && ((q.size() < DP) || popeff);
      if (do_push && !acc) ovf_m = 1'b1;
      if (popeff) void'(q.pop_front());
      if (acc) q.push_back(ev);
      if ((n % PD == PD - 1) && poll_en && (n >= s + 5)) s = n;
      irq_m = irq_next;
   endtask

   task automatic step();
      bit cs_e;
      int addr_e;
      model_eval();
      cs_e   = (n + 1 >= s + 1) && (n + 1 <= s + 3);
      addr_e = n - s;
      @(posedge clk); #1;
      n++;
      total++;
      if (m_cs !== cs_e) begin
         bad++; $display("FAIL m_cs cyc=%0d got=%b exp=%b", n, m_cs, cs_e);
      end
      if (cs_e) begin
         total++;
         if (m_addr !== 2'(addr_e)) begin
            bad++; $display("FAIL m_addr cyc=%0d got=%0d exp=%0d", n, m_addr, addr_e);
         end
      end
      total++;
      if (count !== 3'(q.size())) begin
         bad++; $display("FAIL count cyc=%0d got=%0d exp=%0d", n, count, q.size());
      end
      total++;
      if (evt_valid !== (q.size() != 0)) begin
         bad++; $display("FAIL evt_valid cyc=%0d got=%b exp=%b", n, evt_valid, q.size() != 0);
      end
      total++;
      if (irq !== irq_m) begin
         bad++; $display("FAIL irq cyc=%0d got=%b exp=%b", n, irq, irq_m);
      end
      total++;
      if (overflow !== ovf_m) begin
         bad++; $display("FAIL overflow cyc=%0d got=%b exp=%b", n, overflow, ovf_m);
      end
      if (q.size() != 0) begin
         total++;
         if (evt !== q[0]) begin
            bad++; $display("FAIL evt cyc=%0d got=%h exp=%h", n, evt, q[0]);
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      pop = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic run_sweep();
      int start;
      start = sweeps;
      for (int k = 0; k < 40; k++) begin
         step();
         if (sweeps != start) break;
      end
      total++;
      if (sweeps == start) begin
         bad++; $display("FAIL sweep_timeout got=%0d exp=%0d", sweeps, start + 1);
      end
   endtask

   task automatic test_reset();
      poll_en = 1'b1;
      mx = 9'd300;
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < 12; k++) step();
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (m_cs !== 1'b0)      begin bad++; $display("FAIL rst_m_cs got=%b exp=0", m_cs); end
      total++; if (m_addr !== 2'd0)    begin bad++; $display("FAIL rst_m_addr got=%0d exp=0", m_addr); end
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_evt_valid got=%b exp=0", evt_valid); end
      total++; if (irq !== 1'b0)       begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
      total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
      total++; if (count !== 3'd0)     begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
      mx = 9'd204;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_idle_sweep();
      logic [1:0] seq [3];
      int         nseq;
      apply_reset();
      mb = 3'd0; mx = 9'd204; my = 9'd153;
      poll_en = 1'b1;
      nseq = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (m_cs === 1'b1 && nseq < 3) begin
            seq[nseq] = m_addr;
            nseq++;
         end
      end
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL idle_evt_valid got=%b exp=0", evt_valid); end
      total++; if (nseq !== 3)         begin bad++; $display("FAIL idle_reads got=%0d exp=3", nseq); end
      for (int k = 0; k < nseq; k++) begin
         total++;
         if (seq[k] !== 2'(k)) begin
            bad++; $display("FAIL idle_addr_seq idx=%0d got=%0d exp=%0d", k, seq[k], k);
         end
      end
   endtask

   task automatic test_single_move();
      logic [EW-1:0] exp_e;
      apply_reset();
      mb = 3'd0; mx = 9'd210; my = 9'd153;
      poll_en = 1'b1;
`ifdef MOUSE_BTN_EDGE_EN
      exp_e = {3'd0, 3'd0, 9'd210, 9'd153};
`else
      exp_e = {3'd0, 9'd210, 9'd153};
`endif
      // Tick lands in cycle 3, so the event appears in cycle 8
      for (int k = 0; k < 7; k++) step();
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", evt_valid); end
      step();
      total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b exp=1", evt_valid); end
      total++; if (evt !== exp_e)      begin bad++; $display("FAIL lat_evt got=%h exp=%h", evt, exp_e); end
      total++; if (irq !== 1'b0)       begin bad++; $display("FAIL lat_irq_early got=%b exp=0", irq); end
      step();
      total++; if (irq !== 1'b1)       begin bad++; $display("FAIL lat_irq got=%b exp=1", irq); end
      pop = 1'b1;
      step();
      pop = 1'b0;
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL pop_empty got=%b exp=0", evt_valid); end
      for (int k = 0; k < 10; k++) step();
   endtask

   task automatic test_overflow();
      logic [EW-1:0] exp_e;
      apply_reset();
      mb = 3'd0; my = 9'd153;
      poll_en = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         mx = 9'(i);
         run_sweep();
      end
      total++; if (count !== 3'd4)    begin bad++; $display("FAIL ovf_count got=%0d exp=4", count); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      poll_en = 1'b0;
      for (int i = 1; i <= 4; i++) begin
`ifdef MOUSE_BTN_EDGE_EN
         exp_e = {3'd0, 3'd0, 9'(i), 9'd153};
`else
         exp_e = {3'd0, 9'(i), 9'd153};
`endif
         total++;
         if (evt !== exp_e) begin bad++; $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, evt, exp_e); end
         pop = 1'b1;
         step();
         pop = 1'b0;
      end
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", evt_valid); end
   endtask

   task automatic test_full_pop_push();
      int            xs [4];
      logic [EW-1:0] exp_e;
      apply_reset();
      mb = 3'd0; my = 9'd153;
      poll_en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         mx = 9'(i);
         run_sweep();
      end
      mx = 9'd7;
      for (int k = 0; k < 40 && sweeps == 4; k++) begin
         pop = (n == s + 4);
         step();
      end
      pop = 1'b0;
      total++; if (sweeps !== 5)      begin bad++; $display("FAIL fpp_timeout got=%0d exp=5", sweeps); end
      total++; if (count !== 3'd4)    begin bad++; $display("FAIL fpp_count got=%0d exp=4", count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
      poll_en = 1'b0;
      xs = '{2, 3, 4, 7};
      for (int i = 0; i < 4; i++) begin
`ifdef MOUSE_BTN_EDGE_EN
         exp_e = {3'd0, 3'd0, 9'(xs[i]), 9'd153};
`else
         exp_e = {3'd0, 9'(xs[i]), 9'd153};
`endif
         total++;
         if (evt !== exp_e) begin bad++; $display("FAIL fpp_order idx=%0d got=%h exp=%h", i, evt, exp_e); end
         pop = 1'b1;
         step();
         pop = 1'b0;
      end
   endtask

   task automatic test_reset_mid_sweep();
      apply_reset();
      mb = 3'd0; my = 9'd153;
      poll_en = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         mx = 9'(i);
         run_sweep();
      end
      mx = 9'd300;
      for (int k = 0; k < 40 && n != s + 2; k++) step();
      total++; if (m_cs !== 1'b1) begin bad++; $display("FAIL mid_in_rdx got=%b exp=1", m_cs); end
      rst = 1'b1;
      #1;
      total++; if (m_cs !== 1'b0)      begin bad++; $display("FAIL mid_m_cs got=%b exp=0", m_cs); end
      total++; if (count !== 3'd0)     begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
      total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL mid_overflow got=%b exp=0", overflow); end
      total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mid_evt_valid got=%b exp=0", evt_valid); end
      mx = 9'd204;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < 20; k++) step();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_after_count got=%0d exp=0", count); end
   endtask

   task automatic test_random();
      apply_reset();
      poll_en = 1'b1;
      for (int k = 0; k < 1200; k++) begin
         if (k < 600) pop = ($urandom_range(0, 7) == 0);
         else         pop = ($urandom_range(0, 1) == 0);
         poll_en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 2))
               0:       mb = 3'($urandom_range(0, 7));
               1:       mx = 9'(200 + $urandom_range(0, 7));
               default: my = 9'(150 + $urandom_range(0, 7));
            endcase
         end
         step();
      end
      pop = 1'b0;
   endtask

`ifdef MOUSE_BTN_EDGE_EN
   task automatic test_btn_edge();
      apply_reset();
      mx = 9'd204; my = 9'd153;
      poll_en = 1'b1;
      mb = 3'd1;
      run_sweep();
      total++;
      if (evt !== {3'b001, 3'b001, 9'd204, 9'd153}) begin
         bad++; $display("FAIL btn_press got=%h exp=%h", evt, {3'b001, 3'b001, 9'd204, 9'd153});
      end
      pop = 1'b1;
      step();
      pop = 1'b0;
      mb = 3'd0;
      run_sweep();
      total++;
      if (evt !== {3'b000, 3'b000, 9'd204, 9'd153}) begin
         bad++; $display("FAIL btn_release got=%h exp=%h", evt, {3'b000, 3'b000, 9'd204, 9'd153});
      end
   endtask
`endif

   initial begin
      model_reset();
      #12;
      test_reset();
      test_idle_sweep();
      test_single_move();
      test_overflow();
      test_full_pop_push();
      test_reset_mid_sweep();
      test_random();
`ifdef MOUSE_BTN_EDGE_EN
      test_btn_edge();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
